// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX stages: FSM encoding, parity modes and counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read port of a first-word-fall-through FIFO; the drain side is the master issuing pops.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: runs 0..BIT_CYCLES-1 and pulses bit_end on the last cycle of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = cnt_width(BIT_CYCLES);

  logic [CntW-1:0] cnt_q;

  assign bit_end = (cnt_q == CntW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a FWFT FIFO: one pop per frame, 8N1 with optional parity.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_fifo_drain_if.master  fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BitCycles = CLK_FREQ / BAUD;
  localparam int unsigned BitCntW   = cnt_width(DATA_WIDTH);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  par_q, par_d;
  logic                  timer_clear;
  logic                  bit_end;

  uart_bit_timer #(
    .BIT_CYCLES(BitCycles)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // Gated by rst so no pop can leak out while the block is held in reset.
  assign fifo.fifo_rd = (state_q == StIdle) & ~fifo.fifo_empty & rst;
  assign tx_busy      = (state_q != StIdle);
  assign tx           = tx_q;
  assign tx_done      = done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    par_d       = par_q;
    timer_clear = 1'b0;
    shift_nxt   = shift_q >> 1;

    case (state_q)
      StIdle: begin
        timer_clear = 1'b1;
        tx_d        = 1'b1;
        if (!fifo.fifo_empty) begin
          shift_d   = fifo.fifo_rdata;
          // Parity is fixed at pop time from the whole byte.
          par_d     = (^fifo.fifo_rdata) ^ (PARITY == PAR_ODD);
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_nxt;
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_nxt[0];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        timer_clear = 1'b1;
        tx_d        = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      par_q     <= par_d;
    end
  end

endmodule
